inst_issue_fifo: RTL

//  Parametrised instruction buffer between IF/ID fetch return and the dual-issue decoder.
//  - Accepts up to FETCH_W instruction words per cycle, each tagged with PC and fetch-exception flags.
//  - Presents up to ISSUE_W oldest entries to issue logic, which pops 0..ISSUE_W per cycle.
//  - Generates the fifo stall request back to CTRL and is cleared by the exception flush.

---
 rtl/inst_issue_fifo.sv | 130 +++++++++++++
 1 files changed

// File: rtl/inst_issue_fifo.sv
// -----------------------------------------------------------------------------
// inst_issue_fifo
//   Instruction buffer between the fetch return path and the dual-issue
//   decoder. Up to FETCH_W words (each tagged with PC and fetch-exception
//   flags) are pushed per cycle; the ISSUE_W oldest entries are presented to
//   issue, which pops 0..ISSUE_W per cycle. A flush empties the buffer.
//
//   Optional feature macro: INST_FIFO_BYPASS_EN
//     When defined and the buffer is empty (and issue not stalled), incoming
//     words are presented on out_* in the same cycle; acked bypass words are
//     never written into storage.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               empties the buffer; wins over same-cycle push/pop
//   stall               issue stalled; pops suppressed
//   in_cnt/in_pc/in_inst/in_excp   fetch words offered (word k PC = in_pc+4k)
//   out_valid/out_pc/out_inst/out_excp  head+i entries (zero when invalid)
//   out_ack             words consumed this cycle
//   stallreq_for_fifo   free slots < FETCH_W (from registered count)
//   count               current occupancy
// -----------------------------------------------------------------------------
module inst_issue_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned EXC_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall,
  input  logic [1:0]                 in_cnt,
  input  logic [31:0]                in_pc,
  input  logic [32*FETCH_W-1:0]      in_inst,
  input  logic [EXC_W-1:0]           in_excp,
  output logic [ISSUE_W-1:0]         out_valid,
  output logic [32*ISSUE_W-1:0]      out_pc,
  output logic [32*ISSUE_W-1:0]      out_inst,
  output logic [EXC_W*ISSUE_W-1:0]   out_excp,
  input  logic [1:0]                 out_ack,
  output logic                       stallreq_for_fifo,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]      mem_pc_q   [DEPTH];
  logic [31:0]      mem_inst_q [DEPTH];
  logic [EXC_W-1:0] mem_excp_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0] push_n;   // words accepted this cycle
  logic [1:0] pop_n;    // words consumed this cycle
  logic [1:0] skip_n;   // leading incoming words consumed by bypass, never stored

  assign count             = count_q;
  assign stallreq_for_fifo = (CW'(DEPTH) - count_q) < CW'(FETCH_W);

  // Bypass pops are taken from the incoming words rather than from storage,
  // so they reduce the stored word count instead of advancing head.
  always_comb begin
    push_n = stallreq_for_fifo ? 2'd0 : in_cnt;
    pop_n  = stall ? 2'd0 : out_ack;
    skip_n = 2'd0;
`ifdef INST_FIFO_BYPASS_EN
    if (count_q == '0 && !stall) begin
      skip_n = pop_n;
    end
`endif
    count_d = count_q + CW'(push_n) - CW'(pop_n);
    head_d  = head_q + PW'(pop_n) - PW'(skip_n);
    tail_d  = tail_q + PW'(push_n) - PW'(skip_n);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; out_* are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int unsigned k = 0; k < FETCH_W; k++) begin
        if (k >= 32'(skip_n) && k < 32'(push_n)) begin
          mem_pc_q[tail_q + PW'(k) - PW'(skip_n)]   <= in_pc + 32'(4 * k);
          mem_inst_q[tail_q + PW'(k) - PW'(skip_n)] <= in_inst[32*k +: 32];
          mem_excp_q[tail_q + PW'(k) - PW'(skip_n)] <= in_excp;
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_inst  = '0;
    out_excp  = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      out_valid[i] = count_q > CW'(i);
      if (out_valid[i]) begin
        out_pc[32*i +: 32]         = mem_pc_q[head_q + PW'(i)];
        out_inst[32*i +: 32]       = mem_inst_q[head_q + PW'(i)];
        out_excp[EXC_W*i +: EXC_W] = mem_excp_q[head_q + PW'(i)];
      end
`ifdef INST_FIFO_BYPASS_EN
      if (count_q == '0 && !stall) begin
        out_valid[i] = 32'(in_cnt) > i;
        if (out_valid[i] && i < FETCH_W) begin
          out_pc[32*i +: 32]         = in_pc + 32'(4 * i);
          out_inst[32*i +: 32]       = in_inst[32*i +: 32];
          out_excp[EXC_W*i +: EXC_W] = in_excp;
        end
      end
`endif
    end
  end

endmodule
